uart_packet_tx: RTL and testbench

- Synthesizable UART transmitter that sends a two-byte command packet: a command byte, then a data byte, back-to-back on one serial line.
- Line format: 8N1, or 8E1 when parity is enabled.
- Sits on the far end of the link opposite uart_rx. It is the serial source the RX path receives commands from, both in the bench and on the board.
- Owns its own bit timing, latches the whole packet on accept, and reports completion with a one-cycle done pulse.

---
 rtl/uart_packet_tx.sv | 187 ++++++++++++++++++
 tb/tb_uart_packet_tx.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/uart_packet_tx.sv
// uart_packet_tx
// Serial transmitter for a two-byte command packet: the command byte, then
// the data byte, back-to-back on one line. Frames are 8N1, or 8E1 when
// PARITY_EN=1. Bit timing is generated internally, and both bytes are
// latched when the packet is accepted.
//
// Ports:
//   i_Clock      system clock; all logic is on the rising edge
//   i_Reset_n    synchronous active-low reset
//   i_Pkt_DV     packet-valid strobe, sampled only in IDLE
//   i_Pkt_Cmd    command byte (sent first)
//   i_Pkt_Data   data byte (sent second)
//   o_Tx_Serial  serial line, idles high
//   o_Tx_Active  high from packet accept until the last stop bit ends
//   o_Byte_Idx   0 while sending the command byte, 1 while sending the data byte
//   o_Tx_Done    one-cycle pulse once the packet is complete
module uart_packet_tx #(
  parameter int CLKS_PER_BIT = 87,
  parameter int PARITY_EN    = 1
) (
  input  logic       i_Clock,
  input  logic       i_Reset_n,
  input  logic       i_Pkt_DV,
  input  logic [7:0] i_Pkt_Cmd,
  input  logic [7:0] i_Pkt_Data,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Active,
  output logic       o_Byte_Idx,
  output logic       o_Tx_Done
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [7:0]       data_q, data_d;
  logic             serial_q, serial_d;
  logic             active_q, active_d;
  logic             idx_q, idx_d;
  logic             done_q, done_d;

  logic [7:0] cur_byte;
  logic       bit_end;

  assign cur_byte = idx_q ? data_q : cmd_q;
  assign bit_end  = (cnt_q == CNT_MAX);

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      cmd_q    <= '0;
      data_q   <= '0;
      serial_q <= 1'b1;
      active_q <= 1'b0;
      idx_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      cmd_q    <= cmd_d;
      data_q   <= data_d;
      serial_q <= serial_d;
      active_q <= active_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
    end
  end

  // The line value is computed for the state being entered, so the registered
  // output changes on the same edge as the state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    cmd_d    = cmd_q;
    data_d   = data_q;
    serial_d = serial_q;
    active_d = active_q;
    idx_d    = idx_q;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        serial_d = 1'b1;
        active_d = 1'b0;
        idx_d    = 1'b0;
        cnt_d    = '0;
        bit_d    = '0;
        if (i_Pkt_DV) begin
          cmd_d    = i_Pkt_Cmd;
          data_d   = i_Pkt_Data;
          active_d = 1'b1;
          serial_d = 1'b0;
          state_d  = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          cnt_d    = '0;
          bit_d    = '0;
          serial_d = cur_byte[0];
          state_d  = S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            if (PARITY_EN != 0) begin
              serial_d = ^cur_byte;
              state_d  = S_PARITY;
            end else begin
              serial_d = 1'b1;
              state_d  = S_STOP;
            end
          end else begin
            bit_d    = bit_q + 3'd1;
            serial_d = cur_byte[bit_q + 3'd1];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          cnt_d    = '0;
          serial_d = 1'b1;
          state_d  = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (!idx_q) begin
            // Second byte starts straight after the first stop bit.
            idx_d    = 1'b1;
            serial_d = 1'b0;
            state_d  = S_START;
          end else begin
            idx_d    = 1'b0;
            active_d = 1'b0;
            done_d   = 1'b1;
            serial_d = 1'b1;
            state_d  = S_DONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        serial_d = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        serial_d = 1'b1;
        active_d = 1'b0;
        idx_d    = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
  end

  assign o_Tx_Serial = serial_q;
  assign o_Tx_Active = active_q;
  assign o_Byte_Idx  = idx_q;
  assign o_Tx_Done   = done_q;

endmodule

// File: tb/tb_uart_packet_tx.sv
// Testbench for uart_packet_tx at CLKS_PER_BIT=4, PARITY_EN=1. A frame-level
// model derives every output from the packet start offset, and it is compared
// with the DUT on every cycle. Literal checks from hand-worked examples fix the
// model's behaviour, followed by a randomized phase.
module tb_uart_packet_tx;
  localparam int CPB = 4;
  localparam int P   = 1;
  localparam int HALF = (10 + P) * CPB;
  localparam int L    = 2 * HALF;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dv = 1'b0;
  logic [7:0] cmd = '0;
  logic [7:0] data = '0;
  logic       ser, act, idx, done;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int m_k = -1;
  logic [7:0] m_cmd = '0, m_data = '0;
  bit   armed = 1'b0;
  int   done_cnt = 0;
  int   done_times[$];

  uart_packet_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(P)) dut (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Pkt_DV(dv), .i_Pkt_Cmd(cmd),
    .i_Pkt_Data(data), .o_Tx_Serial(ser), .o_Tx_Active(act),
    .o_Byte_Idx(idx), .o_Tx_Done(done));

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    total_cnt++;
    if (actual == expected) pass_cnt++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, actual, expected);
  endtask

  // Frame bit p (0=start, 1..8 data LSB first, then optional parity, stop).
  function automatic logic frame_bit(input logic [7:0] b, input int p);
    if (p == 0) return 1'b0;
    if (p <= 8) return b[p-1];
    if (P != 0 && p == 9) return ^b;
    return 1'b1;
  endfunction

  // Model: m_k is the cycle offset from the first start-bit cycle, -1 when idle.
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      armed = 1'b1;
      m_k = -1;
    end else if (m_k == -1 || m_k >= L + 1) begin
      if (dv) begin
        m_k = 0;
        m_cmd = cmd;
        m_data = data;
      end else begin
        m_k = -1;
      end
    end else begin
      m_k++;
    end
  end

  always @(negedge clk) begin
    logic e_ser, e_act, e_idx, e_done;
    if (armed) begin
      e_ser = 1'b1; e_act = 1'b0; e_idx = 1'b0; e_done = 1'b0;
      if (m_k >= 0 && m_k < L) begin
        e_idx = (m_k >= HALF);
        e_act = 1'b1;
        e_ser = frame_bit(e_idx ? m_data : m_cmd, (m_k % HALF) / CPB);
      end else if (m_k == L) begin
        e_done = 1'b1;
      end
      check("serial", int'(ser), int'(e_ser));
      check("active", int'(act), int'(e_act));
      check("byte_idx", int'(idx), int'(e_idx));
      check("done", int'(done), int'(e_done));
      if (done === 1'b1) begin
        done_cnt++;
        done_times.push_back(cyc);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves the bench in the first start-bit cycle (offset 0).
  task automatic send(input logic [7:0] c, input logic [7:0] d);
    dv = 1'b1; cmd = c; data = d;
    tick(1);
    dv = 1'b0;
  endtask

  logic seq [22] = '{0,1,1,0,1,0,1,0,1,1,1, 0,1,1,0,1,1,1,0,0,1,1};

  initial begin
    int base;
    // Reset state
    rst_n = 1'b0;
    tick(3);
    check("rst_serial", int'(ser), 1);
    check("rst_active", int'(act), 0);
    check("rst_idx", int'(idx), 0);
    check("rst_done", int'(done), 0);
    rst_n = 1'b1;
    tick(2);

    // 0xAB / 0x3B: mid-bit line samples, byte index flip and done timing
    send(8'hAB, 8'h3B);
    for (int k = 0; k < 90; k++) begin
      if (k % CPB == 2 && k < L) check("seq_bit", int'(ser), int'(seq[k / CPB]));
      if (k == 43) check("idx_before_flip", int'(idx), 0);
      if (k == 44) check("idx_after_flip", int'(idx), 1);
      if (k == 87) check("active_last_stop", int'(act), 1);
      check("done_at_88", int'(done), (k == 88) ? 1 : 0);
      tick(1);
    end

    // 0x00 / 0xFF: both parity bits are 0
    send(8'h00, 8'hFF);
    tick(9 * CPB + 2);
    check("parity_cmd", int'(ser), 0);
    tick(HALF);
    check("parity_data", int'(ser), 0);
    tick(L + 4 - (9 * CPB + 2) - HALF);

    // DV re-asserted mid-packet is ignored
    base = done_cnt;
    send(8'h5A, 8'hC3);
    tick(20);
    dv = 1'b1; cmd = 8'h11; data = 8'h22;
    tick(5);
    dv = 1'b0;
    tick(70);
    check("single_done", done_cnt - base, 1);

    // Reset during data bit 3 of the command byte
    base = done_cnt;
    send(8'hC7, 8'h19);
    tick(17);
    rst_n = 1'b0;
    tick(1);
    check("midrst_serial", int'(ser), 1);
    check("midrst_active", int'(act), 0);
    rst_n = 1'b1;
    tick(100);
    check("midrst_no_done", done_cnt - base, 0);
    send(8'h96, 8'h4E);
    tick(L + 4);
    check("post_rst_done", done_cnt - base, 1);

    // DV held high for three packets: done pulses spaced L+2 apart
    base = done_cnt;
    dv = 1'b1; cmd = 8'hE1; data = 8'h7F;
    tick(1);
    tick(2 * (L + 2) + 5);
    dv = 1'b0;
    tick(L + 10);
    check("held_done_count", done_cnt - base, 3);
    if (done_cnt - base == 3) begin
      check("held_spacing1", done_times[base+1] - done_times[base], 90);
      check("held_spacing2", done_times[base+2] - done_times[base+1], 90);
    end

    // Randomized phase: random DV, bytes changing every cycle, rare resets
    for (int i = 0; i < 3000; i++) begin
      dv = ($urandom_range(0, 9) == 0);
      cmd = 8'($urandom);
      data = 8'($urandom);
      rst_n = ($urandom_range(0, 599) != 0);
      tick(1);
    end
    rst_n = 1'b1;
    dv = 1'b0;
    tick(L + 4);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
